main_mem_loader: RTL
====================

MAIN_MEM_LOADER -- requirements
Module: main_mem_loader

Interface
REQ-001 Parameter N_WORDS, default 100; number of 32-bit words loaded before start and read back after done.
REQ-002 Parameter BASE_ADDR, default 0; byte address of word 0 in the accelerator slave memory.
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid / in_data / in_ready  input 1 / input 32 / output 1  input word stream to load.
REQ-006 S_oe_ram  output  2  slave read enable, per channel; only bit 0 used.
REQ-007 S_we_ram  output  2  slave write enable, per channel; only bit 0 used.
REQ-008 S_addr_ram / S_Wdata_ram / S_data_ram_size  output 18 / 128 / 14  address, data and access size, 9/64/7 bits per channel, channel 0 in low bits.
REQ-009 Sout_Rdata_ram / Sout_DataRdy  input 128 / 2  read data and per-channel data-ready.
REQ-010 start_port / done_port  output 1 / input 1  accelerator start pulse and completion.
REQ-011 out_valid / out_data / out_ready  output 1 / output 32 / input 1  read-back word stream.
REQ-012 busy / cycle_count  output 1 / output 32  nonzero state indicator; start-to-done latency.

Function
REQ-013 FSM states IDLE, LOAD, WRITE, START, RUN, RD_REQ, RD_WAIT, EMIT; IDLE exits to LOAD on the first cycle after reset.
REQ-014 LOAD: in_ready=1; a word is accepted when in_valid&&in_ready; the FSM then moves to WRITE.
REQ-015 WRITE (1 cycle): S_we_ram[0]=1, addr=BASE_ADDR+4*idx (low 9 bits), Wdata[31:0]=accepted word, size=32; all other bits 0.
REQ-016 After WRITE: idx increments; idx==N_WORDS -> START with idx cleared; otherwise -> LOAD. Sustained throughput is 1 word per 2 cycles.
REQ-017 START: start_port=1 for exactly one cycle; then -> RUN.
REQ-018 RUN: wait until done_port==1 is sampled, then -> RD_REQ. A done_port seen in any other state is ignored.
REQ-019 RD_REQ (1 cycle): S_oe_ram[0]=1, addr=BASE_ADDR+4*idx, size=32; then -> RD_WAIT.
REQ-020 RD_WAIT: hold until Sout_DataRdy[0]=1; capture Sout_Rdata_ram[31:0] into out_data; then -> EMIT. Covers any read latency of 1 cycle or more; a DataRdy in the same cycle as oe is not valid.
REQ-021 EMIT: out_valid=1 and out_data held stable until out_ready. On handshake idx increments; idx==N_WORDS -> IDLE, otherwise -> RD_REQ.
REQ-022 Outputs not driven by the current state are 0; S_oe_ram and S_we_ram are never both set.
REQ-023 busy=1 in every state except IDLE.
REQ-024 After the final read-back the block reloads: IDLE -> LOAD begins the next run.

Reset
REQ-025 Reset forces state IDLE and idx=0. All outputs are 0, including cycle_count and out_data, on the cycle after reset is sampled.
REQ-026 Reset asserted mid-operation, in any state, aborts the run immediately with no further slave strobes and no start_port pulse.

Configuration
REQ-027 Macro MAIN_MEM_LOADER_CYCLE_COUNT_EN defined: cycle_count clears to 0 on start_port, then increments every cycle in RUN, saturating at 2^32-1, and holds after done until the next start_port.
REQ-028 Macro MAIN_MEM_LOADER_CYCLE_COUNT_EN undefined: cycle_count is tied to 0 and no counter logic is present.

Structure
REQ-029 Shared package main_mem_loader_pkg holds: the FSM state enum, ACCESS_SIZE_32 (7'd32), the per-channel widths (ADDR_CH_W=9, DATA_CH_W=64, SIZE_CH_W=7) and CH0 index 0.
REQ-030 One sub-module, main_mem_loader_slave_drv: combinational packing of the channel-0 oe/we/addr/data/size fields onto the 2-channel buses, with zero fill.

Verification
REQ-031 N_WORDS=4, inputs 4,3,2,1 with in_valid held high -> 4 WRITE pulses at addresses 0,4,8,12 on alternate cycles, then exactly one start_port cycle.
REQ-032 done_port asserted 10 cycles after start_port, memory model returns 1,2,3,4 with 2-cycle read latency -> out_data 1,2,3,4 in order; with the macro defined, cycle_count=10.
REQ-033 out_ready held low 5 cycles during EMIT -> out_valid and out_data stable for all 5 cycles; no new S_oe_ram until the handshake completes.
REQ-034 in_valid gapped 0/1 randomly -> write count stays exactly N_WORDS and addresses stay contiguous.
REQ-035 Reset pulsed during RUN and during LOAD -> all outputs 0 next cycle, no start_port; the next run loads from address BASE_ADDR.
REQ-036 done_port held high from reset -> ignored through LOAD; the block advances to RD_REQ only after start_port.

Source files
------------

// File: rtl/main_mem_loader_pkg.sv
// Shared types and channel geometry for the main-memory loader.
package main_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_START,
    ST_RUN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_EMIT
  } state_t;

  localparam logic [6:0] ACCESS_SIZE_32 = 7'd32;
  localparam int ADDR_CH_W = 9;
  localparam int DATA_CH_W = 64;
  localparam int SIZE_CH_W = 7;
  localparam int N_CH      = 2;
  localparam int CH0       = 0;

  // Byte address of a word, truncated to the slave's per-channel address width.
  function automatic logic [ADDR_CH_W-1:0] word_addr(input logic [31:0] base,
                                                     input logic [31:0] idx);
    logic [31:0] byte_addr;
    byte_addr = base + (idx << 2);
    return byte_addr[ADDR_CH_W-1:0];
  endfunction

endpackage

// File: rtl/main_mem_loader_slave_drv.sv
// Packs the channel-0 access fields onto the two-channel slave buses; channel 1
// and all unused bits are driven to zero.
module main_mem_loader_slave_drv
  import main_mem_loader_pkg::*;
(
  input  logic                      oe,
  input  logic                      we,
  input  logic [ADDR_CH_W-1:0]      addr,
  input  logic [31:0]               wdata,
  input  logic [SIZE_CH_W-1:0]      size,
  output logic [N_CH-1:0]           S_oe_ram,
  output logic [N_CH-1:0]           S_we_ram,
  output logic [N_CH*ADDR_CH_W-1:0] S_addr_ram,
  output logic [N_CH*DATA_CH_W-1:0] S_Wdata_ram,
  output logic [N_CH*SIZE_CH_W-1:0] S_data_ram_size
);

  always_comb begin
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    S_oe_ram[CH0]   = oe;
    S_we_ram[CH0]   = we;
    S_addr_ram[CH0*ADDR_CH_W +: ADDR_CH_W]      = addr;
    S_Wdata_ram[CH0*DATA_CH_W +: 32]            = wdata;
    S_data_ram_size[CH0*SIZE_CH_W +: SIZE_CH_W] = size;
  end

endmodule

// File: rtl/main_mem_loader.sv
// Loads N_WORDS words into accelerator memory, starts it, waits for done and
// streams the results back. Optional counter: MAIN_MEM_LOADER_CYCLE_COUNT_EN.
//   state   | meaning
//   IDLE    | one-cycle gap before a new run
//   LOAD    | waiting for an input word
//   WRITE   | write strobe for the accepted word
//   START   | one-cycle accelerator start pulse
//   RUN     | waiting for done_port
//   RD_REQ  | read strobe for word idx
//   RD_WAIT | waiting for channel-0 data ready
//   EMIT    | presenting the read word until out_ready
module main_mem_loader
  import main_mem_loader_pkg::*;
#(
  parameter int N_WORDS   = 100,
  parameter int BASE_ADDR = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic [1:0]   S_oe_ram,
  output logic [1:0]   S_we_ram,
  output logic [17:0]  S_addr_ram,
  output logic [127:0] S_Wdata_ram,
  output logic [13:0]  S_data_ram_size,
  input  logic [127:0] Sout_Rdata_ram,
  input  logic [1:0]   Sout_DataRdy,
  output logic         start_port,
  input  logic         done_port,
  output logic         out_valid,
  output logic [31:0]  out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic [31:0]  cycle_count
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [31:0]            word_q;
  logic [31:0]            rdata_q;
  logic                   idx_step;
  logic                   oe, we;
  logic [ADDR_CH_W-1:0]   addr;
  logic                   unused_inputs;

  assign unused_inputs = ^{Sout_Rdata_ram[127:32], Sout_DataRdy[1]};

  // idx wraps to 0 after the last word of both the load and the read-back pass.
  assign idx_step = (state == ST_WRITE) || (state == ST_EMIT && out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_LOAD && in_valid)
        word_q <= in_data;
      if (state == ST_RD_WAIT && Sout_DataRdy[CH0])
        rdata_q <= Sout_Rdata_ram[31:0];
      if (idx_step)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    oe         = 1'b0;
    we         = 1'b0;
    start_port = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE:    state_nxt = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        we        = 1'b1;
        state_nxt = (idx == LAST_IDX) ? ST_START : ST_LOAD;
      end
      ST_START: begin
        start_port = 1'b1;
        state_nxt  = ST_RUN;
      end
      ST_RUN:     if (done_port) state_nxt = ST_RD_REQ;
      ST_RD_REQ: begin
        oe        = 1'b1;
        state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (Sout_DataRdy[CH0]) state_nxt = ST_EMIT;
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_RD_REQ;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign out_data = out_valid ? rdata_q : '0;
  assign addr     = (oe || we) ? word_addr(32'(BASE_ADDR), 32'(idx)) : '0;

  main_mem_loader_slave_drv u_slave_drv (
    .oe              (oe),
    .we              (we),
    .addr            (addr),
    .wdata           (we ? word_q : 32'd0),
    .size            ((oe || we) ? ACCESS_SIZE_32 : 7'd0),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size)
  );

`ifdef MAIN_MEM_LOADER_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  // Cleared by the start pulse, counts RUN cycles, saturates, holds otherwise.
  always_ff @(posedge clock) begin
    if (reset)
      cyc_q <= '0;
    else if (state == ST_START)
      cyc_q <= '0;
    else if (state == ST_RUN && cyc_q != '1)
      cyc_q <= cyc_q + 1'b1;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule
